// File: rtl/reg_dump_streamer_if.sv
// reg_dump_streamer_if: bundles the register-file read port, the start/PC
// capture inputs, the status strobes and the valid/ready beat stream of the
// register dump engine. The engine side uses the master modport; the core and
// the stream consumer use the slave modport.
interface reg_dump_streamer_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [DATA_W-1:0] pc_in;
    logic [4:0]        rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [5:0]        out_index;
    logic              out_last;
    logic              busy;
    logic              freeze;
    logic              done;

    // Dump engine side
    modport master (
        input  start, pc_in, rd_data, out_ready,
        output rd_addr, out_valid, out_data, out_index, out_last,
               busy, freeze, done
    );

    // Core / register file / stream consumer side
    modport slave (
        output start, pc_in, rd_data, out_ready,
        input  rd_addr, out_valid, out_data, out_index, out_last,
               busy, freeze, done
    );
endinterface

// File: rtl/reg_dump_streamer.sv
// reg_dump_streamer: on a start pulse snapshots the PC, then walks the register
// file read port from $0 to $ra and streams every word over valid/ready.
// Beat tags: 6'h20 = PC, 0..31 = register number, 6'h21 = checksum.
// Optional feature macro: REG_DUMP_CHECKSUM_EN appends an XOR checksum beat
// (PC ^ all registers) after R31 and moves out_last onto it.
// Every output is registered; freeze mirrors busy so the core stays stalled
// for the whole dump.
module reg_dump_streamer #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic                clk,
    input  logic                rst,
    reg_dump_streamer_if.master bus
);
    localparam logic [4:0] LAST_REG = 5'(NREGS - 1);
    localparam logic [5:0] IDX_PC   = 6'h20;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam logic [5:0] IDX_SUM  = 6'h21;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PC     = 3'd1,
        ST_REGS   = 3'd2,
`ifdef REG_DUMP_CHECKSUM_EN
        ST_SUM    = 3'd3,
`endif
        ST_FINISH = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_out_valid,  w_out_valid_nxt;
    logic [DATA_W-1:0] r_out_data,   w_out_data_nxt;
    logic [5:0]        r_out_index,  w_out_index_nxt;
    logic              r_out_last,   w_out_last_nxt;
    logic [4:0]        r_rd_addr,    w_rd_addr_nxt;
    logic              r_busy,       w_busy_nxt;
    logic              r_done,       w_done_nxt;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum,        w_sum_nxt;
`endif

    logic              w_hs;
    logic              w_at_last_reg;

    // A beat leaves the output slot this cycle; the slot may then be reloaded.
    assign w_hs          = r_out_valid & bus.out_ready;
    // The beat currently in the slot is the final register word.
    assign w_at_last_reg = (r_out_index == {1'b0, LAST_REG});

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: every transition out of a beat state waits for a handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_PC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PC: begin
                if (w_hs) begin
                    w_state_nxt = ST_REGS;
                end else begin
                    w_state_nxt = ST_PC;
                end
            end
            ST_REGS: begin
                if (w_hs && w_at_last_reg) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    w_state_nxt = ST_SUM;
`else
                    w_state_nxt = ST_FINISH;
`endif
                end else begin
                    w_state_nxt = ST_REGS;
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            ST_SUM: begin
                if (w_hs) begin
                    w_state_nxt = ST_FINISH;
                end else begin
                    w_state_nxt = ST_SUM;
                end
            end
`endif
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output logic: next contents of the output slot, read address and status flags.
    always_comb begin
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_index_nxt = r_out_index;
        w_out_last_nxt  = r_out_last;
        w_rd_addr_nxt   = r_rd_addr;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
        w_sum_nxt       = r_sum;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_data_nxt  = bus.pc_in;
                    w_out_index_nxt = IDX_PC;
                    w_out_last_nxt  = 1'b0;
                    w_rd_addr_nxt   = 5'd0;
                    w_busy_nxt      = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                    w_sum_nxt       = bus.pc_in;
`endif
                end else begin
                    w_out_valid_nxt = 1'b0;
                    w_busy_nxt      = 1'b0;
                end
            end
            ST_PC, ST_REGS: begin
                if (w_hs && (r_state == ST_REGS) && w_at_last_reg) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    w_out_data_nxt  = r_sum;
                    w_out_index_nxt = IDX_SUM;
                    w_out_last_nxt  = 1'b1;
`else
                    w_out_valid_nxt = 1'b0;
                    w_out_last_nxt  = 1'b0;
                    w_busy_nxt      = 1'b0;
                    w_done_nxt      = 1'b1;
`endif
                end else if (w_hs) begin
                    // rd_addr already points at the register this beat carries.
                    w_out_data_nxt  = bus.rd_data;
                    w_out_index_nxt = {1'b0, r_rd_addr};
`ifdef REG_DUMP_CHECKSUM_EN
                    w_out_last_nxt  = 1'b0;
                    w_sum_nxt       = r_sum ^ bus.rd_data;
`else
                    w_out_last_nxt  = (r_rd_addr == LAST_REG);
`endif
                    w_rd_addr_nxt   = (r_rd_addr == LAST_REG) ? 5'd0 : r_rd_addr + 5'd1;
                end else begin
                    w_out_valid_nxt = r_out_valid;
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            ST_SUM: begin
                if (w_hs) begin
                    w_out_valid_nxt = 1'b0;
                    w_out_last_nxt  = 1'b0;
                    w_busy_nxt      = 1'b0;
                    w_done_nxt      = 1'b1;
                end else begin
                    w_out_valid_nxt = r_out_valid;
                end
            end
`endif
            ST_FINISH: begin
                w_out_valid_nxt = 1'b0;
                w_busy_nxt      = 1'b0;
            end
            default: begin
                w_out_valid_nxt = 1'b0;
                w_busy_nxt      = 1'b0;
            end
        endcase
    end

    // Output and datapath registers with synchronous reset; a reset aborts any dump silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= 6'd0;
            r_out_last  <= 1'b0;
            r_rd_addr   <= 5'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_index <= w_out_index_nxt;
            r_out_last  <= w_out_last_nxt;
            r_rd_addr   <= w_rd_addr_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
`ifdef REG_DUMP_CHECKSUM_EN
            r_sum       <= w_sum_nxt;
`endif
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_index = r_out_index;
    assign bus.out_last  = r_out_last;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.busy      = r_busy;
    assign bus.freeze    = r_busy;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_reg_dump_streamer.sv
// tb_reg_dump_streamer: table-driven bench for reg_dump_streamer. Each table
// row gives the PC, register-file fill, ready pattern and the hand-computed
// cycle (relative to the start edge T) where done must pulse. Hand-written
// sequences cover mid-dump reset and, when REG_DUMP_CHECKSUM_EN is defined,
// the checksum beat.
module tb_reg_dump_streamer;
    logic        clk;
    logic        rst;
    logic [31:0] rf [32];
    int          n_checks;
    int          n_errors;

`ifdef REG_DUMP_CHECKSUM_EN
    localparam int N_BEATS = 34;
`else
    localparam int N_BEATS = 33;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  pat;       // out_ready for cycle T+n is pat[(n-1)%4]
        bit          extra;     // pulse start again at T+5 and T+20
        logic [31:0] mul;       // rf[i] = i*mul ^ xr
        logic [31:0] xr;
        int          exp_done;  // cycle offset of done pulse from T
    } vec_t;

    reg_dump_streamer_if #(.DATA_W(32)) bus ();

    reg_dump_streamer #(.DATA_W(32), .NREGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.rd_data = rf[bus.rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_data"},  64'(bus.out_data),  64'd0);
        chk({tag, "_index"}, 64'(bus.out_index), 64'd0);
        chk({tag, "_last"},  64'(bus.out_last),  64'd0);
        chk({tag, "_rdaddr"},64'(bus.rd_addr),   64'd0);
        chk({tag, "_busy"},  64'(bus.busy),      64'd0);
        chk({tag, "_freeze"},64'(bus.freeze),    64'd0);
        chk({tag, "_done"},  64'(bus.done),      64'd0);
    endtask

    // Runs one dump from the IDLE state and checks every cycle of it.
    task automatic run_dump(input string tag, input logic [31:0] pc, input logic [3:0] pat,
                            input bit extra, input int exp_done,
                            output logic [31:0] last_data, output logic [5:0] last_idx);
        int          beats;
        int          dones;
        bit          finished;
        bit          prev_stall;
        logic [31:0] pd;
        logic [5:0]  pi;
        logic        pl;
        logic [31:0] acc;
        logic [31:0] ed;
        logic [5:0]  ei;
        logic        el;
        acc = pc;
        for (int i = 0; i < 32; i++) acc = acc ^ rf[i];
        beats = 0; dones = 0; finished = 1'b0; prev_stall = 1'b0;
        pd = 32'd0; pi = 6'd0; pl = 1'b0;
        last_data = 32'd0; last_idx = 6'd0;
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.pc_in     = pc;
        bus.out_ready = 1'b0;
        @(posedge clk);                           // edge T
        for (int n = 1; n <= 200 && !finished; n++) begin
            #1;
            bus.start     = extra && (n == 5 || n == 20);
            bus.out_ready = pat[(n - 1) % 4];
            @(negedge clk);
            if (n == 1) chk({tag, "_rdaddr_r0"}, 64'(bus.rd_addr), 64'd0);
            chk($sformatf("%s_freeze_n%0d", tag, n), 64'(bus.freeze), 64'(bus.busy));
            chk($sformatf("%s_busy_n%0d", tag, n), 64'(bus.busy), 64'(n < exp_done));
            chk($sformatf("%s_valid_n%0d", tag, n), 64'(bus.out_valid), 64'(n < exp_done));
            chk($sformatf("%s_done_n%0d", tag, n), 64'(bus.done), 64'(n == exp_done));
            if (prev_stall) begin
                chk($sformatf("%s_hold_data_n%0d", tag, n), 64'(bus.out_data), 64'(pd));
                chk($sformatf("%s_hold_idx_n%0d", tag, n), 64'(bus.out_index), 64'(pi));
                chk($sformatf("%s_hold_last_n%0d", tag, n), 64'(bus.out_last), 64'(pl));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (beats == 0) begin
                    ed = pc; ei = 6'h20; el = 1'b0;
                end else if (beats <= 32) begin
                    ed = rf[beats - 1]; ei = 6'(beats - 1); el = (beats == N_BEATS - 1);
                end else begin
                    ed = acc; ei = 6'h21; el = 1'b1;
                end
                chk($sformatf("%s_data_b%0d", tag, beats), 64'(bus.out_data), 64'(ed));
                chk($sformatf("%s_idx_b%0d", tag, beats), 64'(bus.out_index), 64'(ei));
                chk($sformatf("%s_last_b%0d", tag, beats), 64'(bus.out_last), 64'(el));
                last_data = bus.out_data;
                last_idx  = bus.out_index;
                beats++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            pd = bus.out_data; pi = bus.out_index; pl = bus.out_last;
            if (bus.done) dones++;
            if (n >= exp_done + 2) finished = 1'b1;
            @(posedge clk);
        end
        bus.start = 1'b0;
        chk({tag, "_beat_count"}, 64'(beats), 64'(N_BEATS));
        chk({tag, "_done_pulses"}, 64'(dones), 64'd1);
    endtask

    initial begin
        vec_t        vecs [4];
        logic [31:0] ld;
        logic [5:0]  li;
        n_checks = 0;
        n_errors = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.pc_in     = 32'd0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h11111111;

`ifdef REG_DUMP_CHECKSUM_EN
        vecs[0] = '{pc: 32'h00000040, pat: 4'b1111, extra: 1'b0, mul: 32'h11111111, xr: 32'h0,        exp_done: 35};
        vecs[1] = '{pc: 32'h00000040, pat: 4'b1001, extra: 1'b0, mul: 32'h11111111, xr: 32'h0,        exp_done: 69};
        vecs[2] = '{pc: 32'h00000040, pat: 4'b1111, extra: 1'b1, mul: 32'h11111111, xr: 32'h0,        exp_done: 35};
        vecs[3] = '{pc: 32'hDEADBEEC, pat: 4'b1011, extra: 1'b0, mul: 32'h01000193, xr: 32'hA5A5A5A5, exp_done: 46};
`else
        vecs[0] = '{pc: 32'h00000040, pat: 4'b1111, extra: 1'b0, mul: 32'h11111111, xr: 32'h0,        exp_done: 34};
        vecs[1] = '{pc: 32'h00000040, pat: 4'b1001, extra: 1'b0, mul: 32'h11111111, xr: 32'h0,        exp_done: 66};
        vecs[2] = '{pc: 32'h00000040, pat: 4'b1111, extra: 1'b1, mul: 32'h11111111, xr: 32'h0,        exp_done: 34};
        vecs[3] = '{pc: 32'hDEADBEEC, pat: 4'b1011, extra: 1'b0, mul: 32'h01000193, xr: 32'hA5A5A5A5, exp_done: 45};
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("por");
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 32; i++) rf[i] = (32'(i) * vecs[v].mul) ^ vecs[v].xr;
            run_dump($sformatf("v%0d", v), vecs[v].pc, vecs[v].pat, vecs[v].extra,
                     vecs[v].exp_done, ld, li);
            chk($sformatf("v%0d_final_idx", v), 64'(li), 64'(N_BEATS == 34 ? 6'h21 : 6'd31));
        end

        // Reset asserted in cycle T+10 aborts the dump with no done pulse.
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h11111111;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.pc_in = 32'h00001234;
        @(posedge clk);                           // edge T
        for (int n = 1; n <= 9; n++) begin
            #1;
            bus.start     = 1'b0;
            bus.out_ready = 1'b1;
            @(posedge clk);
        end
        #1;
        rst = 1'b1;                               // cycle T+10
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            chk($sformatf("midrst_no_done_%0d", n), 64'(bus.done), 64'd0);
            chk($sformatf("midrst_idle_%0d", n), 64'(bus.out_valid), 64'd0);
        end
        run_dump("restart", 32'h00000040, 4'b1111, 1'b0, vecs[0].exp_done, ld, li);

`ifdef REG_DUMP_CHECKSUM_EN
        // Checksum beat with PC=1, all registers zero except R5.
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rf[5] = 32'hFFFF0000;
        run_dump("csum", 32'h00000001, 4'b1111, 1'b0, 35, ld, li);
        chk("csum_hand_data", 64'(ld), 64'h00000000FFFF0001);
        chk("csum_hand_idx", 64'(li), 64'h21);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/reg_dump_streamer.md
# reg_dump_streamer

Hardware read-out engine for the MIPS core: on a start pulse it snapshots the program counter, then walks the register file's read port from `$0` to `$ra`, streaming every word out over a valid/ready interface. It is the in-silicon counterpart of the end-of-run PC/register dump. It sits beside `RF` and `ProgCounter`, and the host-side UART or trace logic drains its output. While a dump is in progress it holds the core frozen so the register contents stay stable.

## Interface
Parameters:
- `DATA_W`, 32: width of the PC and register words.
- `NREGS`, 32: number of architectural registers walked; indices run 0..NREGS-1.

Ports:
- `clk`  in  1: single system clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: one-cycle request to begin a dump; sampled only in IDLE.
- `pc_in`  in  DATA_W: current PC value, captured on the accepted `start` cycle.
- `rd_addr`  out  5: register-file read address.
- `rd_data`  in  DATA_W: register-file read data, combinational from `rd_addr`.
- `out_valid`  out  1: stream beat is valid.
- `out_ready`  in  1: consumer accepts the beat when high together with `out_valid`.
- `out_data`  out  DATA_W: beat payload.
- `out_index`  out  6: beat tag. 6'h20 = PC, 0..31 = register number, 6'h21 = checksum.
- `out_last`  out  1: marks the final beat of the dump.
- `busy`  out  1: a dump is in progress.
- `freeze`  out  1: stall request to the core; equal to `busy`.
- `done`  out  1: one-cycle pulse after the final beat is accepted.

## Operation
- States: IDLE, PC, REGS, SUM (present only with the macro), FINISH.
- IDLE, `start`=1:
  - latch `pc_in` into `out_data`.
  - set `out_index`=6'h20 and `out_valid`=1.
  - set `busy`=1 and `freeze`=1.
  - go to PC.
- Beat order: PC, then R0, R1, ..., R31, then the checksum (macro only).
- Output register: loads the next beat when the slot is empty or is being handshaken this cycle (`out_valid & out_ready`). It holds `out_data`, `out_index` and `out_last` stable while `out_valid & !out_ready`.
- `rd_addr` always presents the index of the next register to load. Register k's payload is `rd_data` sampled at the edge that loads beat k.
- `out_last`=1 on the R31 beat, or on the checksum beat if that beat is enabled.
- When the last beat handshakes: go to FINISH, drop `out_valid`, pulse `done` for one cycle, drop `busy` and `freeze`, then return to IDLE.
- `start` outside IDLE is ignored (not queued).
- R0 is streamed as read (expected 0); no special-casing.
- `rst`: at the next edge, all state returns to reset values; any dump in progress is aborted with no `done`.
- Reset values: `out_valid`=0, `out_data`=0, `out_index`=0, `out_last`=0, `rd_addr`=0, `busy`=0, `freeze`=0, `done`=0. State is IDLE and the checksum accumulator is 0.

## Timing
- `start` sampled high at edge T → PC beat valid from T+1. `busy` and `freeze` are high from T+1.
- With `out_ready` held at 1, throughput is one beat per cycle:
  - beats at cycles T+1..T+33; R31 is on T+33.
  - `done` at T+34; `busy` low at T+34.
- Each cycle of `out_ready`=0 stretches the dump by exactly one cycle. No beat is ever dropped or duplicated.
- `rd_addr` for R0 is presented in cycle T+1. The core must not retire register writes once `freeze` is high. Writes at edge T are visible.
- `done` and the `busy` fall are coincident. A new `start` is accepted in the cycle after `done`.

## Configuration
- `REG_DUMP_CHECKSUM_EN` defined:
  - appends one extra beat after R31 with `out_index`=6'h21.
  - payload is the XOR of the PC word and all 32 register words.
  - `out_last` moves to this beat; the unhandshaken dump length is 34 beats and `done` is at T+35.
- Undefined: the SUM state and the accumulator are not compiled in; the dump is 33 beats and ends on R31.

## Test plan
- Preload RF with Ri=i*0x11111111 (truncated), `pc_in`=0x00000040, start, `out_ready`=1 → 33 beats: 0x40 tagged 6'h20, then R0..R31 tagged 0..31. `out_last` only on R31; `done` at T+34.
- Same stimulus with `out_ready` toggling 1,0,0,1 repeatedly → identical beat sequence. Each stalled beat's data, index and last stay stable; total length is 33 handshakes.
- `start` pulsed again at T+5 and T+20 during a dump → ignored. Exactly one dump and one `done` pulse.
- `rst` asserted at T+10 mid-dump → next cycle all outputs at reset values and no `done`. A fresh `start` afterwards restarts cleanly from the PC beat.
- With `REG_DUMP_CHECKSUM_EN`, PC=0x1 and all registers 0 except R5=0xFFFF0000 → 34th beat tagged 6'h21 with data 0xFFFF0001 and `out_last`=1; `done` at T+35.
- Check `freeze`==`busy` in every cycle. `rd_addr` must never exceed 31 and must present R0 at T+1.
